ahbl_arbiter_2: RTL



---
 rtl/ahbl_arbiter_2.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ahbl_arbiter_2.sv
// Two-master AHB-Lite arbiter. A master that loses a conflict has its address
// phase captured and replayed later; it is stalled through its own HREADY until then.
module ahbl_arbiter_2 #(
    parameter bit RR         = 1'b1,
    parameter bit BURST_LOCK = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] M0_HADDR,
    input  logic [1:0]  M0_HTRANS,
    input  logic        M0_HWRITE,
    input  logic [2:0]  M0_HSIZE,
    input  logic [31:0] M0_HWDATA,
    output logic        M0_HREADY,
    output logic [31:0] M0_HRDATA,
    input  logic [31:0] M1_HADDR,
    input  logic [1:0]  M1_HTRANS,
    input  logic        M1_HWRITE,
    input  logic [2:0]  M1_HSIZE,
    input  logic [31:0] M1_HWDATA,
    output logic        M1_HREADY,
    output logic [31:0] M1_HRDATA,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA
);
    localparam logic [1:0] TR_IDLE = 2'b00;
    localparam logic [1:0] TR_SEQ  = 2'b11;

    logic [37:0] r_hold0, r_hold1;
    logic        r_pend0, r_pend1;
    logic        r_dvalid, r_downer, r_last;

    logic [37:0] w_live0, w_live1, w_bus;
    logic        w_act0, w_act1, w_req0, w_req1;
    logic        w_gv, w_g, w_last_seq;
    logic        w_issue0, w_issue1, w_cap0, w_cap1;

    assign w_live0 = {M0_HADDR, M0_HTRANS, M0_HWRITE, M0_HSIZE};
    assign w_live1 = {M1_HADDR, M1_HTRANS, M1_HWRITE, M1_HSIZE};

    // Ready depends only on registered state and HREADY, so the live-request
    // terms below never loop back through the grant.
    assign M0_HREADY = r_pend0 ? 1'b0 : (r_dvalid && !r_downer) ? HREADY : 1'b1;
    assign M1_HREADY = r_pend1 ? 1'b0 : (r_dvalid &&  r_downer) ? HREADY : 1'b1;

    assign w_act0 = M0_HTRANS[1] & M0_HREADY;
    assign w_act1 = M1_HTRANS[1] & M1_HREADY;
    assign w_req0 = r_pend0 | w_act0;
    assign w_req1 = r_pend1 | w_act1;
    assign w_gv   = w_req0 | w_req1;

    assign w_last_seq = r_last ? (M1_HTRANS == TR_SEQ && !r_pend1)
                               : (M0_HTRANS == TR_SEQ && !r_pend0);

    always_comb begin
        w_g = 1'b0;
        if (w_req1 && !w_req0) begin
            w_g = 1'b1;
        end else if (w_req0 && w_req1) begin
            if (BURST_LOCK && w_last_seq) w_g = r_last;
            else if (RR)                  w_g = ~r_last;
            else                          w_g = 1'b0;
        end
    end

    always_comb begin
        w_bus = {M0_HADDR, TR_IDLE, M0_HWRITE, M0_HSIZE};
        if (w_gv) begin
            if (w_g) w_bus = r_pend1 ? r_hold1 : w_live1;
            else     w_bus = r_pend0 ? r_hold0 : w_live0;
        end
    end

    assign {HADDR, HTRANS, HWRITE, HSIZE} = w_bus;
    assign HWDATA    = r_downer ? M1_HWDATA : M0_HWDATA;
    assign M0_HRDATA = HRDATA;
    assign M1_HRDATA = HRDATA;

    // A grant only takes effect on a ready cycle; any other live request is parked.
    assign w_issue0 = HREADY && w_gv && !w_g;
    assign w_issue1 = HREADY && w_gv &&  w_g;
    assign w_cap0   = w_act0 && !w_issue0;
    assign w_cap1   = w_act1 && !w_issue1;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_hold0  <= '0;
            r_hold1  <= '0;
            r_pend0  <= 1'b0;
            r_pend1  <= 1'b0;
            r_dvalid <= 1'b0;
            r_downer <= 1'b0;
            r_last   <= 1'b1;
        end else begin
            if (HREADY) begin
                r_dvalid <= w_gv;
                if (w_gv) begin
                    r_downer <= w_g;
                    r_last   <= w_g;
                end
            end
            if (w_cap0) begin
                r_pend0 <= 1'b1;
                r_hold0 <= w_live0;
            end else if (w_issue0) begin
                r_pend0 <= 1'b0;
            end
            if (w_cap1) begin
                r_pend1 <= 1'b1;
                r_hold1 <= w_live1;
            end else if (w_issue1) begin
                r_pend1 <= 1'b0;
            end
        end
    end
endmodule
